// File: rtl/mult_pkg.sv
// Shared definitions for the multicycle radix-2 Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    localparam int MULT_ITERS = 32;
    localparam int CNT_W      = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    // The 64-bit product fits in 32 signed bits only if the upper half is pure sign.
    function automatic logic product_overflow(input logic [31:0] upper, input logic sign);
        return (upper != {32{sign}});
    endfunction

endpackage

// File: rtl/booth_addsub_33.sv
// 33-bit accumulator add/subtract of a sign-extended 32-bit operand.
module booth_addsub_33 (
    input  logic [32:0] a,
    input  logic [31:0] m,
    input  logic        sub,
    output logic [32:0] sum
);

    logic [31:0] b_s;
    logic        b_hi_s;
    logic [31:0] lo_s;
    logic        c32_s;

    // Subtraction as a + ~m + 1; bit 32 sees the inverted sign extension.
    assign b_s    = m ^ {32{sub}};
    assign b_hi_s = m[31] ^ sub;

    cla_adder_32 u_cla (
        .a    (a[31:0]),
        .b    (b_s),
        .cin  (sub),
        .sum  (lo_s),
        .cout (c32_s)
    );

    assign sum = {a[32] ^ b_hi_s ^ c32_s, lo_s};

endmodule

// File: rtl/cla_adder_32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained on group carry.
module cla_adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] gen_s;
    logic [31:0] prop_s;
    logic [32:0] carry_s;

    assign gen_s  = a & b;
    assign prop_s = a ^ b;

    // Per-group lookahead carries, group carry rippled to the next group.
    always_comb begin
        logic cg;
        int   base;
        carry_s = 33'd0;
        cg      = cin;
        carry_s[0] = cin;
        for (int k = 0; k < 8; k++) begin
            base = 4 * k;
            carry_s[base+1] = gen_s[base] | (prop_s[base] & cg);
            carry_s[base+2] = gen_s[base+1] | (prop_s[base+1] & gen_s[base])
                            | (prop_s[base+1] & prop_s[base] & cg);
            carry_s[base+3] = gen_s[base+2] | (prop_s[base+2] & gen_s[base+1])
                            | (prop_s[base+2] & prop_s[base+1] & gen_s[base])
                            | (prop_s[base+2] & prop_s[base+1] & prop_s[base] & cg);
            carry_s[base+4] = gen_s[base+3] | (prop_s[base+3] & gen_s[base+2])
                            | (prop_s[base+3] & prop_s[base+2] & gen_s[base+1])
                            | (prop_s[base+3] & prop_s[base+2] & prop_s[base+1] & gen_s[base])
                            | (prop_s[base+3] & prop_s[base+2] & prop_s[base+1] & prop_s[base] & cg);
            cg = carry_s[base+4];
        end
    end

    assign sum  = prop_s ^ carry_s[31:0];
    assign cout = carry_s[32];

endmodule

// File: rtl/mult_booth_32_bit.sv
// Multicycle signed 32x32 radix-2 Booth multiplier, low-word result plus overflow.
// Optional feature: define MULT_OVERFLOW_EN to compute overflow (otherwise tied to 0).
module mult_booth_32_bit
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic             ready
);

    mult_state_e state_r;
    mult_state_e state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [31:0]      m_r;
    logic [32:0]      a_r;
    logic [31:0]      q_r;
    logic             qm1_r;
    logic [31:0]      result_r;
    logic             overflow_r;
    logic             busy_r;
    logic             ready_r;

    logic             accept_s;
    logic             step_s;
    logic             finish_s;
    logic             add_en_s;
    logic             sub_s;
    logic [32:0]      sum_s;
    logic [32:0]      acc_s;
    logic [32:0]      a_sh_s;
    logic [31:0]      q_sh_s;

    // Booth recoding of the current multiplier bit pair.
    always_comb begin
        add_en_s = 1'b0;
        sub_s    = 1'b0;
        case ({q_r[0], qm1_r})
            2'b01: begin
                add_en_s = 1'b1;
                sub_s    = 1'b0;
            end
            2'b10: begin
                add_en_s = 1'b1;
                sub_s    = 1'b1;
            end
            default: begin
                add_en_s = 1'b0;
                sub_s    = 1'b0;
            end
        endcase
    end

    booth_addsub_33 u_addsub (
        .a   (a_r),
        .m   (m_r),
        .sub (sub_s),
        .sum (sum_s)
    );

    // Select the updated accumulator, then arithmetic-shift {A, Q, q_m1}.
    always_comb begin
        acc_s = a_r;
        if (add_en_s) begin
            acc_s = sum_s;
        end else begin
            acc_s = a_r;
        end
        a_sh_s = {acc_s[32], acc_s[32:1]};
        q_sh_s = {acc_s[0], q_r[31:1]};
    end

    // Next-state and step controls.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (count_r == CNT_LAST) begin
                    finish_s    = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand, accumulator and iteration counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_r     <= 32'd0;
            a_r     <= 33'd0;
            q_r     <= 32'd0;
            qm1_r   <= 1'b0;
            count_r <= 5'd0;
        end else if (accept_s) begin
            m_r     <= multiplicand;
            a_r     <= 33'd0;
            q_r     <= multiplier;
            qm1_r   <= 1'b0;
            count_r <= 5'd0;
        end else if (step_s) begin
            a_r     <= a_sh_s;
            q_r     <= q_sh_s;
            qm1_r   <= q_r[0];
            count_r <= count_r + 5'd1;
        end
    end

    // Registered outputs; result and overflow load on the final step and then hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_r   <= 32'd0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            busy_r  <= (state_nxt_s != IDLE);
            ready_r <= finish_s;
            if (finish_s) begin
                result_r <= q_sh_s;
`ifdef MULT_OVERFLOW_EN
                overflow_r <= product_overflow(a_sh_s[31:0], q_sh_s[31]);
`else
                overflow_r <= 1'b0;
`endif
            end
        end
    end

    assign result   = result_r;
    assign overflow = overflow_r;
    assign busy     = busy_r;
    assign ready    = ready_r;

endmodule
